xs3_digit_packer: RTL and testbench

//  Serial Excess-3 digit receiver. Takes one Excess-3 nibble per handshake,

---
 rtl/xs3_digit_packer_if.sv | 27 ++
 rtl/xs3_digit_packer.sv | 99 +++++++++
 tb/tb_xs3_digit_packer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/xs3_digit_packer_if.sv
// Digit-in / word-out handshake bundle for xs3_digit_packer.
// The master side feeds Excess-3 digits and consumes packed BCD words; the packer is the slave.
interface xs3_digit_packer_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_xs3;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [CW-1:0]         out_count;
    logic                  out_err;

    modport master (
        output in_valid, in_xs3, in_last, out_ready,
        input  in_ready, out_valid, out_bcd, out_count, out_err
    );

    modport slave (
        input  in_valid, in_xs3, in_last, out_ready,
        output in_ready, out_valid, out_bcd, out_count, out_err
    );
endinterface

// File: rtl/xs3_digit_packer.sv
// Serial Excess-3 digit receiver: converts each digit to BCD and packs a word MSD-first.
// Build option XS3_ERR_DROP_EN: discard words containing illegal codes instead of flagging them.
module xs3_digit_packer #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    xs3_digit_packer_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    acc, acc_nxt, acc_shift;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            err, err_nxt;
    logic            illegal;
    logic [3:0]      bcd;
    logic            in_ready, out_valid;

    // Legal codes are 3..C; anything else is stored as digit 0 and flags the word.
    assign illegal   = (bus.in_xs3 < 4'h3) || (bus.in_xs3 > 4'hC);
    assign bcd       = illegal ? 4'h0 : bus.in_xs3 - 4'h3;
    assign acc_shift = (acc << 4) | W'(bcd);
    assign cnt_inc   = cnt + CW'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        err_nxt   = err;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_nxt = acc_shift;
                    cnt_nxt = cnt_inc;
                    err_nxt = err | illegal;
                    if (bus.in_last || (cnt_inc == LAST_CNT)) begin
`ifdef XS3_ERR_DROP_EN
                        // A bad word never reaches HOLD; restart collection immediately.
                        if (err_nxt) begin
                            acc_nxt = '0;
                            cnt_nxt = '0;
                            err_nxt = 1'b0;
                        end else begin
                            state_nxt = HOLD;
                        end
`else
                        state_nxt = HOLD;
`endif
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    // The accumulator doubles as the word register: it is frozen while in HOLD.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bcd   = acc;
    assign bus.out_count = cnt;
`ifdef XS3_ERR_DROP_EN
    assign bus.out_err   = 1'b0;
`else
    assign bus.out_err   = err;
`endif
endmodule

// File: tb/tb_xs3_digit_packer.sv
// Scoreboard bench for xs3_digit_packer: DIGITS=4 main instance plus a DIGITS=1 instance.
module tb_xs3_digit_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xs3_digit_packer_if #(.DIGITS(4)) bus  ();
    xs3_digit_packer_if #(.DIGITS(1)) bus1 ();

    xs3_digit_packer #(.DIGITS(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    xs3_digit_packer #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [15:0] bcd;
        logic [2:0]  count;
        logic        err;
    } word_t;

    word_t exp_q[$];
    word_t mon_w;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Words flagged with an error never appear when the drop build is selected.
    task automatic push_word(input logic [15:0] bcd, input logic [2:0] count, input logic err);
        word_t w;
        w.bcd = bcd; w.count = count; w.err = err;
`ifdef XS3_ERR_DROP_EN
        if (!err) exp_q.push_back(w);
`else
        exp_q.push_back(w);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", 32'(bus.out_bcd), 32'hFFFF_FFFF);
            end else begin
                mon_w = exp_q.pop_front();
                check("word_bcd",   32'(bus.out_bcd),   32'(mon_w.bcd));
                check("word_count", 32'(bus.out_count), 32'(mon_w.count));
                check("word_err",   32'(bus.out_err),   32'(mon_w.err));
            end
        end
    end

    task automatic send(input logic [3:0] x, input logic last);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_xs3   = x;
        bus.in_last  = last;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!done) check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_bcd"},   32'(bus.out_bcd),   32'd0);
        check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
        check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
    endtask

    initial begin
        logic [15:0] acc;
        logic        err;
        logic [3:0]  x;
        logic        ill;
        int          len;
        bit          last;

        bus.in_valid  = 1'b0; bus.in_xs3  = 4'h0; bus.in_last  = 1'b0; bus.out_ready  = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_xs3 = 4'h0; bus1.in_last = 1'b0; bus1.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Full word without in_last; out_valid must rise right after the 4th accept.
        bus.out_ready = 1'b0;
        push_word(16'h1234, 3'd4, 1'b0);
        send(4'h4, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b0);
        check("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
        send(4'h7, 1'b0);
        check("t1_latency_valid", 32'(bus.out_valid), 32'd1);
        check("t1_in_ready_low",  32'(bus.in_ready),  32'd0);
        bus.out_ready = 1'b1;

        // Early termination, boundary codes C and 3.
        push_word(16'h0090, 3'd2, 1'b0);
        send(4'hC, 1'b0); send(4'h3, 1'b1);

        // Illegal code inside a word, then a legal word.
        push_word(16'h1034, 3'd4, 1'b1);
        send(4'h4, 1'b0); send(4'hF, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0);
`ifdef XS3_ERR_DROP_EN
        check("t3_dropped_no_valid", 32'(bus.out_valid), 32'd0);
`else
        check("t3_err_word_valid",   32'(bus.out_valid), 32'd1);
`endif
        push_word(16'h5678, 3'd4, 1'b0);
        send(4'h8, 1'b0); send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0);
        drain();

        // Stall the consumer for 5 cycles; outputs must stay put.
        bus.out_ready = 1'b0;
        push_word(16'h1234, 3'd4, 1'b0);
        send(4'h4, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("t4_stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("t4_stall_bcd",       32'(bus.out_bcd),   32'h1234);
            check("t4_stall_count",     32'(bus.out_count), 32'd4);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_ready_after_take", 32'(bus.in_ready), 32'd1);

        // Eight back-to-back digits form two words in order.
        push_word(16'h1234, 3'd4, 1'b0);
        push_word(16'h5678, 3'd4, 1'b0);
        for (int i = 0; i < 8; i++) send(4'(4 + i), 1'b0);
        drain();

        // Reset in the middle of a word discards it.
        send(4'h4, 1'b0); send(4'h5, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("t5_midword_reset");
        rst = 1'b0;
        push_word(16'h1234, 3'd4, 1'b0);
        send(4'h4, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b0); send(4'h7, 1'b0);
        drain();

        // DIGITS=1: every digit is a whole word, with or without in_last.
        for (int i = 0; i < 3; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_xs3   = 4'h8;
            bus1.in_last  = (i == 1);
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
            bus1.in_last  = 1'b0;
            check("t6_valid", 32'(bus1.out_valid), 32'd1);
            check("t6_bcd",   32'(bus1.out_bcd),   32'h5);
            check("t6_count", 32'(bus1.out_count), 32'd1);
            check("t6_err",   32'(bus1.out_err),   32'd0);
            bus1.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus1.out_ready = 1'b0;
            check("t6_taken", 32'(bus1.out_valid), 32'd0);
        end

        // Random words against a reference model of the conversion.
        for (int w = 0; w < 15; w++) begin
            len = $urandom_range(1, 4);
            acc = '0;
            err = 1'b0;
            for (int d = 0; d < len; d++) begin
                x    = 4'($urandom_range(0, 15));
                ill  = (x < 4'h3) || (x > 4'hC);
                acc  = (acc << 4) | 16'(ill ? 4'h0 : x - 4'h3);
                err  = err | ill;
                last = (d == len - 1) && ((len < 4) || ($urandom_range(0, 1) == 1));
                if (d == len - 1) push_word(acc, 3'(len), err);
                send(x, last);
            end
        end
        drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
